// File: rtl/comp_16_bit_core.sv
// comp_16_bit_core: registered 16-bit magnitude comparator built from four
// 4-bit slice compares merged from the most significant slice down.
// SIGNED_MODE=1 compares two's-complement operands.
// Optional macro COMP_PIPE_EN adds a register stage between the slice
// compares and the merge (latency 2 instead of 1, still one result/cycle).
module comp_16_bit_core #(
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  output logic        comp,
  output logic        a_greater_b,
  output logic        equal,
  output logic        out_valid
);

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so the slice hardware is identical in both modes.
  logic [15:0] op_a;
  logic [15:0] op_b;
  assign op_a = {in1[15] ^ SIGNED_MODE, in1[14:0]};
  assign op_b = {in2[15] ^ SIGNED_MODE, in2[14:0]};

  logic [3:0] slice_lt;
  logic [3:0] slice_gt;

  for (genvar g = 0; g < 4; g++) begin : g_slice
    assign slice_lt[g] = (op_a[4*g +: 4] < op_b[4*g +: 4]);
    assign slice_gt[g] = (op_a[4*g +: 4] > op_b[4*g +: 4]);
  end

  // Returns {lt, gt, eq}; the highest unequal slice decides, so later
  // (higher) iterations overwrite lower ones.
  function automatic logic [2:0] merge_slices(input logic [3:0] lt,
                                              input logic [3:0] gt);
    logic [2:0] r;
    r = 3'b001;
    for (int i = 0; i < 4; i++) begin
      if (lt[i] || gt[i]) r = {lt[i], gt[i], 1'b0};
    end
    return r;
  endfunction

  logic [3:0] m_lt;
  logic [3:0] m_gt;
  logic       m_valid;

`ifdef COMP_PIPE_EN
  logic [3:0] s1_lt;
  logic [3:0] s1_gt;
  logic       s1_valid;

  // Slice-result stage; slice flags only load on valid input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_lt    <= 4'h0;
      s1_gt    <= 4'h0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lt <= slice_lt;
        s1_gt <= slice_gt;
      end
    end
  end

  assign m_lt    = s1_lt;
  assign m_gt    = s1_gt;
  assign m_valid = s1_valid;
`else
  assign m_lt    = slice_lt;
  assign m_gt    = slice_gt;
  assign m_valid = in_valid;
`endif

  logic [2:0] merged;
  assign merged = merge_slices(m_lt, m_gt);

  // Result register: flags load on valid and hold otherwise; out_valid tracks valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp        <= 1'b0;
      a_greater_b <= 1'b0;
      equal       <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= m_valid;
      if (m_valid) begin
        comp        <= merged[2];
        a_greater_b <= merged[1];
        equal       <= merged[0];
      end
    end
  end

endmodule

// File: tb/tb_comp_16_bit_core.sv
module tb_comp_16_bit_core;

`ifdef COMP_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        u_comp, u_gt, u_eq, u_ov;
  logic        s_comp, s_gt, s_eq, s_ov;

  int n_tests = 0;
  int n_fail  = 0;

  comp_16_bit_core #(.SIGNED_MODE(1'b0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2),
    .comp(u_comp), .a_greater_b(u_gt), .equal(u_eq), .out_valid(u_ov)
  );

  comp_16_bit_core #(.SIGNED_MODE(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2),
    .comp(s_comp), .a_greater_b(s_gt), .equal(s_eq), .out_valid(s_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  exp_u;
    logic [2:0]  exp_s;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [2:0] exp_u,
                       input logic [2:0] exp_s, input logic exp_v);
    n_tests++;
    if ({u_comp, u_gt, u_eq, u_ov} !== {exp_u, exp_v}) begin
      n_fail++;
      $display("FAIL %s unsigned: got lt/gt/eq/v=%b%b%b%b expected %b%b", name,
               u_comp, u_gt, u_eq, u_ov, exp_u, exp_v);
    end
    n_tests++;
    if ({s_comp, s_gt, s_eq, s_ov} !== {exp_s, exp_v}) begin
      n_fail++;
      $display("FAIL %s signed: got lt/gt/eq/v=%b%b%b%b expected %b%b", name,
               s_comp, s_gt, s_eq, s_ov, exp_s, exp_v);
    end
  endtask

  initial begin
    vecs[0]  = '{16'h003D, 16'h003E, LT, LT};
    vecs[1]  = '{16'h1234, 16'h1234, EQ, EQ};
    vecs[2]  = '{16'h8000, 16'h7FFF, GT, LT};
    vecs[3]  = '{16'h0F00, 16'h0FFF, LT, LT};
    vecs[4]  = '{16'hF000, 16'h0FFF, GT, LT};
    vecs[5]  = '{16'h0000, 16'h0000, EQ, EQ};
    vecs[6]  = '{16'hFFFF, 16'h0000, GT, LT};
    vecs[7]  = '{16'h7FFF, 16'h8000, LT, GT};
    vecs[8]  = '{16'hFFFE, 16'hFFFF, LT, LT};
    vecs[9]  = '{16'h0010, 16'h0001, GT, GT};
    vecs[10] = '{16'h8000, 16'h8001, LT, LT};
    vecs[11] = '{16'h5A5A, 16'h5A4B, GT, GT};
    vecs[12] = '{16'hFFFF, 16'hFFFF, EQ, EQ};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    in1      = 16'hFFFF;
    in2      = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_state", 3'b000, 3'b000, 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("post_release_idle", 3'b000, 3'b000, 1'b0);

    // Single-shot vectors: result after LAT edges, then out_valid drops and flags hold.
    for (int i = 0; i < 13; i++) begin
      in1      = vecs[i].a;
      in2      = vecs[i].b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in1      = ~vecs[i].a;
      in2      = ~vecs[i].b;
      repeat (LAT - 1) @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp_u, vecs[i].exp_s, 1'b1);
      @(negedge clk);
      check($sformatf("vec%0d_hold", i), vecs[i].exp_u, vecs[i].exp_s, 1'b0);
    end

    // Back-to-back stream of three, then a bubble.
    in1 = vecs[2].a; in2 = vecs[2].b; in_valid = 1'b1;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      if (c >= LAT && c - LAT < 3)
        check($sformatf("stream_c%0d", c), vecs[2 + c - LAT].exp_u,
              vecs[2 + c - LAT].exp_s, 1'b1);
      else if (c - LAT == 3)
        check("stream_drop", vecs[4].exp_u, vecs[4].exp_s, 1'b0);
      if (c < 3) begin
        in1 = vecs[2 + c].a; in2 = vecs[2 + c].b; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Reset mid-stream: async clear, in-flight data discarded.
    in1 = vecs[0].a; in2 = vecs[0].b; in_valid = 1'b1;
    @(negedge clk);
    in1 = vecs[9].a; in2 = vecs[9].b;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (3) @(negedge clk);
    check("flush_after_reset", 3'b000, 3'b000, 1'b0);

    // First transaction after release follows normal latency.
    in1 = vecs[7].a; in2 = vecs[7].b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (LAT > 1) check("post_reset_early", 3'b000, 3'b000, 1'b0);
    repeat (LAT - 1) @(negedge clk);
    check("post_reset_first", vecs[7].exp_u, vecs[7].exp_s, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comp_16_bit_core.md
COMP_16_BIT_CORE -- requirements
Module: comp_16_bit

Interface
REQ-001 Parameter SIGNED_MODE, default 0: 0 = unsigned compare; 1 = two's-complement compare.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  qualifies in1/in2 this cycle.
REQ-005 in1  input  16  operand A.
REQ-006 in2  input  16  operand B.
REQ-007 comp  output  1  registered result: 1 when A < B.
REQ-008 a_greater_b  output  1  registered: 1 when A > B.
REQ-009 equal  output  1  registered: 1 when A == B.
REQ-010 out_valid  output  1  registered: flags valid on comp/a_greater_b/equal.

Function
REQ-011 The compare SHALL be hierarchical: four 4-bit slices (bits 3:0, 7:4, 11:8, 15:12), each producing less/greater/equal, merged MSB-slice-first (first unequal slice from the top decides).
REQ-012 Unsigned mode: A < B by unsigned magnitude; signed mode: bit 15 treated as sign, so a negative operand is less than any non-negative one.
REQ-013 Exactly one of comp, a_greater_b, equal SHALL be 1 whenever out_valid is 1.
REQ-014 Latency: in_valid=1 sampled at edge N -> results and out_valid=1 at edge N+1 (macro off).
REQ-015 in_valid=0 at an edge -> out_valid=0 next cycle; comp/a_greater_b/equal hold their last values.
REQ-016 Back-to-back in_valid SHALL give one result per cycle, no bubbles, no stall input.
REQ-017 Boundaries: 0x0000 vs 0x0000 -> equal; 0xFFFF vs 0x0000 -> greater (unsigned) / less (signed); 0x8000 vs 0x7FFF -> greater (unsigned) / less (signed).

Reset
REQ-018 rst_n low SHALL immediately force comp, a_greater_b, equal, out_valid and all pipeline registers to 0, independent of clk.
REQ-019 Reset asserted mid-operation SHALL discard in-flight results; first valid output after release follows REQ-014 from the first sampled in_valid.
REQ-020 rst_n release is synchronous-safe: no output changes until the next rising edge with in_valid=1.

Configuration
REQ-021 Macro COMP_PIPE_EN: when defined, slice results SHALL be registered in an extra stage before the merge, giving latency 2 cycles (in_valid at N -> out_valid at N+2), throughput still 1/cycle, extra stage cleared by rst_n.
REQ-022 Without COMP_PIPE_EN, latency SHALL be 1 cycle per REQ-014 with no intermediate registers.

Verification
REQ-023 SIGNED_MODE=0, in1=0x003D, in2=0x003E, in_valid=1 -> next cycle comp=1, a_greater_b=0, equal=0, out_valid=1.
REQ-024 in1=0x1234, in2=0x1234 -> equal=1, comp=0, a_greater_b=0.
REQ-025 in1=0x8000, in2=0x7FFF -> unsigned: a_greater_b=1; SIGNED_MODE=1: comp=1.
REQ-026 in1=0x0F00, in2=0x0FFF (decided by low slice only) -> comp=1; in1=0xF000, in2=0x0FFF -> a_greater_b=1 (unsigned).
REQ-027 Stream 3 valid pairs, then in_valid=0, then rst_n low mid-stream -> results in order at the configured latency, out_valid drops after the stream, all outputs 0 immediately on reset.
REQ-028 Repeat REQ-023..REQ-027 with COMP_PIPE_EN defined -> identical values, each delayed one extra cycle.
